// File: rtl/addsub_pkg.sv
// Shared op encodings and width-generic signed limit helpers for the add/sub pipeline.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_LDA = 2'b11
  } op_t;

  function automatic int signed_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int signed_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational signed add/subtract with overflow detection and optional clamping.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned N   = 6,
  parameter bit          SAT = 1'b0
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] result,
  output logic         ovf
);

  localparam logic [N-1:0] MaxVal = N'(signed_max(N));
  localparam logic [N-1:0] MinVal = N'(signed_min(N));

  logic [N:0] x_ext;
  logic [N:0] y_ext;
  logic [N:0] sum;

  assign x_ext = {x[N-1], x};
  assign y_ext = {y[N-1], y};
  assign sum   = sub ? (x_ext - y_ext) : (x_ext + y_ext);
  assign ovf   = sum[N] ^ sum[N-1];

  // The extra top bit carries the sign of the true (unbounded) result.
  always_comb begin
    result = sum[N-1:0];
    if (SAT && ovf) begin
      result = sum[N] ? MinVal : MaxVal;
    end
  end

endmodule

// File: rtl/addsub_accum_pipe.sv
// Two-stage valid/ready add/sub/accumulate pipeline with overflow flags and optional saturation.
module addsub_accum_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned N   = 6,
  parameter bit          SAT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  logic         s1_valid_q;
  op_t          s1_op_q;
  logic [N-1:0] s1_a_q;
  logic [N-1:0] s1_b_q;
  logic         s2_valid_q;
  logic [N-1:0] result_q;
  logic         ovf_q;
  logic         zero_q;
  logic         neg_q;
  logic [N-1:0] acc_q;

  logic         s2_adv;
  logic         xfer;
  logic         in_fire;
  logic [N-1:0] core_x;
  logic [N-1:0] core_y;
  logic         core_sub;
  logic [N-1:0] core_res;
  logic         core_ovf;
  logic [N-1:0] res_d;
  logic         ovf_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign xfer     = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    core_x   = s1_a_q;
    core_y   = s1_b_q;
    core_sub = 1'b0;
    case (s1_op_q)
      OP_SUB: core_sub = 1'b1;
      OP_ACC: begin
        core_x = acc_q;
        core_y = s1_a_q;
      end
      default: ;
    endcase
  end

  addsub_core #(
    .N   (N),
    .SAT (SAT)
  ) u_core (
    .x      (core_x),
    .y      (core_y),
    .sub    (core_sub),
    .result (core_res),
    .ovf    (core_ovf)
  );

  // LDA bypasses the adder: it can never overflow.
  assign res_d = (s1_op_q == OP_LDA) ? s1_a_q : core_res;
  assign ovf_d = (s1_op_q == OP_LDA) ? 1'b0 : core_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_op_q    <= op_t'(op);
        s1_a_q     <= a;
        s1_b_q     <= b;
      end else if (xfer) begin
        s1_valid_q <= 1'b0;
      end

      // acc is written on the same transfer, so a following ACC in stage 1 sees it.
      if (xfer) begin
        s2_valid_q <= 1'b1;
        result_q   <= res_d;
        ovf_q      <= ovf_d;
        zero_q     <= (res_d == '0);
        neg_q      <= res_d[N-1];
        if (s1_op_q == OP_ACC || s1_op_q == OP_LDA) begin
          acc_q <= res_d;
        end
      end else if (out_valid && out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_accum_pipe.sv
// Bench: wrapping and saturating instances driven in lockstep, checked by table and by model.
module tb_addsub_accum_pipe;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [N-1:0] res0, res1;
  logic         ovf0, ovf1, zero0, zero1, neg0, neg1;

  always #5 clk = ~clk;

  addsub_accum_pipe #(.N(N), .SAT(1'b0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .result    (res0),
    .ovf       (ovf0),
    .zero      (zero0),
    .neg       (neg0)
  );

  addsub_accum_pipe #(.N(N), .SAT(1'b1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .result    (res1),
    .ovf       (ovf1),
    .zero      (zero1),
    .neg       (neg1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {int r; bit o;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   acc_m[2];
  bit   mon_en = 1'b0;
  bit   hv[2];
  int   hr[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [N-1:0] v);
    return int'($signed(v));
  endfunction

  // Reference: exact integer arithmetic, then wrap or clamp into -32..31.
  function automatic void model_step(input int opv, input int av, input int bv, input bit sat,
                                     inout int acc, output int r, output bit o);
    int full;
    case (opv)
      0:       full = av + bv;
      1:       full = av - bv;
      2:       full = acc + av;
      default: full = av;
    endcase
    o = (full > 31) || (full < -32);
    if (!o)       r = full;
    else if (sat) r = (full > 0) ? 31 : -32;
    else          r = ((full + 32) & 63) - 32;
    if (opv >= 2) acc = r;
  endfunction

  task automatic send(input int opv, input int av, input int bv);
    int   budget;
    bit   rdy;
    exp_t e;
    op       = 2'(opv);
    a        = N'(av);
    b        = N'(bv);
    in_valid = 1'b1;
    budget   = 0;
    rdy      = 1'b0;
    forever begin
      #1 rdy = in_ready0;
      @(posedge clk);
      if (rdy) break;
      budget++;
      if (budget > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready got 0 expected 1");
        break;
      end
      @(negedge clk);
    end
    if (rdy && mon_en) begin
      model_step(opv, av, bv, 1'b0, acc_m[0], e.r, e.o);
      q0.push_back(e);
      model_step(opv, av, bv, 1'b1, acc_m[1], e.r, e.o);
      q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic mon_chk(input int idx, input logic v, input logic [N-1:0] r, input logic o,
                         input logic z, input logic ng);
    exp_t e;
    int   qs;
    if (hv[idx]) begin
      chk($sformatf("hold_valid%0d", idx), v, 1);
      chk($sformatf("hold_result%0d", idx), sx(r), hr[idx]);
    end
    if (v && out_ready) begin
      hv[idx] = 1'b0;
      qs = (idx == 0) ? q0.size() : q1.size();
      checks++;
      if (qs == 0) begin
        errors++;
        $display("FAIL extra_beat%0d: got result %0d expected no beat", idx, sx(r));
      end else begin
        if (idx == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        chk($sformatf("res%0d", idx), sx(r), e.r);
        chk($sformatf("ovf%0d", idx), o, int'(e.o));
        chk($sformatf("zero%0d", idx), z, int'(e.r == 0));
        chk($sformatf("neg%0d", idx), ng, int'(e.r < 0));
      end
    end else if (v) begin
      hv[idx] = 1'b1;
      hr[idx] = sx(r);
    end else begin
      hv[idx] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (reset || !mon_en) begin
      hv[0] = 1'b0;
      hv[1] = 1'b0;
    end else begin
      mon_chk(0, out_valid0, res0, ovf0, zero0, neg0);
      mon_chk(1, out_valid1, res1, ovf1, zero1, neg1);
    end
  end

  task automatic clear_model();
    q0.delete();
    q1.delete();
    acc_m[0] = 0;
    acc_m[1] = 0;
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int budget = 0;
    while ((q0.size() != 0 || q1.size() != 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_pending", q0.size() + q1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {int op; int a; int b; int r0; int o0; int r1; int o1;} vec_t;
  vec_t vecs[12];
  bit   stop_rand;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0,   5,   7,  12, 0,  12, 0};
    vecs[1]  = '{0,  20,  15, -29, 1,  31, 1};
    vecs[2]  = '{1, -32,   1,  31, 1, -32, 1};
    vecs[3]  = '{1,   9,   9,   0, 0,   0, 0};
    vecs[4]  = '{0, -32,  -1,  31, 1, -32, 1};
    vecs[5]  = '{1,   0, -32, -32, 1,  31, 1};
    vecs[6]  = '{3,   0,   5,   0, 0,   0, 0};
    vecs[7]  = '{2,  10,   0,  10, 0,  10, 0};
    vecs[8]  = '{2,  10,   0,  20, 0,  20, 0};
    vecs[9]  = '{2,  10,   0,  30, 0,  30, 0};
    vecs[10] = '{2,  10,   0, -24, 1,  31, 1};
    vecs[11] = '{2,  10,   0, -14, 0,  31, 1};

    op = 2'b00;
    a  = '0;
    b  = '0;
    @(negedge clk);
    do_reset();
    chk("rst_out_valid", out_valid0 | out_valid1, 0);
    chk("rst_result", sx(res0) | sx(res1), 0);
    chk("rst_flags", {ovf0, zero0, neg0, ovf1, zero1, neg1}, 0);
    chk("rst_in_ready", in_ready0 & in_ready1, 1);

    // Single isolated beats: latency and exact values from the table.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      in_valid = 1'b0;
      chk($sformatf("lat1_v%0d", i), out_valid0, 0);
      @(negedge clk);
      chk($sformatf("lat2_v%0d", i), out_valid0 & out_valid1, 1);
      chk($sformatf("tres0_v%0d", i), sx(res0), vecs[i].r0);
      chk($sformatf("tovf0_v%0d", i), ovf0, vecs[i].o0);
      chk($sformatf("tzero0_v%0d", i), zero0, int'(vecs[i].r0 == 0));
      chk($sformatf("tneg0_v%0d", i), neg0, int'(vecs[i].r0 < 0));
      chk($sformatf("tres1_v%0d", i), sx(res1), vecs[i].r1);
      chk($sformatf("tovf1_v%0d", i), ovf1, vecs[i].o1);
      chk($sformatf("tneg1_v%0d", i), neg1, int'(vecs[i].r1 < 0));
      @(negedge clk);
    end

    // Back-to-back accumulate chain.
    do_reset();
    mon_en = 1'b1;
    send(3, 0, 0);
    for (int i = 0; i < 4; i++) send(2, 10, 0);
    in_valid = 1'b0;
    drain();

    // Stall with both stages full, then release.
    out_ready = 1'b0;
    fork
      begin
        send(0, 1, 1);
        send(0, 2, 2);
        send(0, 3, 3);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        chk("stall_in_ready", in_ready0, 0);
        chk("stall_out_valid", out_valid0, 1);
        chk("stall_result", sx(res0), 2);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight and acc=17.
    send(3, 17, 0);
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    send(0, 1, 1);
    send(0, 2, 2);
    in_valid = 1'b0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    clear_model();
    @(negedge clk);
    chk("midrst_out_valid", out_valid0 | out_valid1, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready0, 1);
    mon_en = 1'b1;
    send(2, 1, 0);
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure.
    do_reset();
    mon_en    = 1'b1;
    stop_rand = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)) - 32,
               int'($urandom_range(0, 63)) - 32);
          if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
          end
        end
        in_valid  = 1'b0;
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
